// File: rtl/md_feed_decoder.sv
// md_feed_decoder
//   Market-data feed decoder that sits behind rx_parser. It accepts packets
//   whose UDP destination port matches the configured feed port. It decodes
//   the first two payload words into one message, checks that feed sequence
//   numbers are contiguous, and keeps saturating accept/drop counters.
//
// Ports
//   clk, rst               system clock, asynchronous active-high reset
//   s_axis_t*              payload stream from rx_parser (tready is registered)
//   header_valid/udp_dport latched rx_parser header fields, sampled in IDLE only
//   cfg_dport/cfg_enable   feed port filter and global enable
//   msg_*                  decoded message, msg_valid is a one-cycle pulse
//   gap_*                  sequence gap report, pulses together with msg_valid
//   err_short              pulse when a matching packet ends after word 0
//   pkt_accept_cnt/drop    saturating 16-bit packet counters
module md_feed_decoder #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              header_valid,
    input  logic [15:0]       udp_dport,
    input  logic [15:0]       cfg_dport,
    input  logic              cfg_enable,
    output logic              msg_valid,
    output logic [31:0]       msg_seq,
    output logic [7:0]        msg_type,
    output logic [31:0]       msg_price,
    output logic [31:0]       msg_qty,
    output logic              gap_valid,
    output logic [31:0]       gap_expected,
    output logic [31:0]       gap_received,
    output logic              err_short,
    output logic [15:0]       pkt_accept_cnt,
    output logic [15:0]       pkt_drop_cnt
);

    typedef enum logic [2:0] {IDLE, W0, W1, DRAIN, DROP} state_t;

    state_t      state, state_next;
    logic        beat;
    logic        emit;        // W1 beat taken: message goes out next cycle
    logic        short_pkt;   // matching packet ended on word 0
    logic        drop_pkt;    // packet counted as dropped
    logic [31:0] seq_q;       // word 0 fields, held until word 1 arrives
    logic [7:0]  type_q;
    logic [31:0] expected_seq;
    logic        seq_init;    // first message after reset has no gap

    assign beat = s_axis_tvalid & s_axis_tready;

    // NOTE: every combinational output gets a default before the case
    // statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        short_pkt  = 1'b0;
        drop_pkt   = 1'b0;
        case (state)
            IDLE: begin
                // Filter inputs are only looked at here, so a packet keeps
                // its accept/drop decision even if cfg changes mid-packet.
                if (header_valid)
                    state_next = (cfg_enable && (udp_dport == cfg_dport)) ? W0 : DROP;
            end
            W0: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        short_pkt  = 1'b1;
                        drop_pkt   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = W1;
                    end
                end
            end
            W1: begin
                if (beat) begin
                    emit       = 1'b1;
                    state_next = s_axis_tlast ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (beat && s_axis_tlast)
                    state_next = IDLE;
            end
            DROP: begin
                if (beat && s_axis_tlast) begin
                    drop_pkt   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_next;
            // tready follows the next state, so it is held low while the
            // decoder waits in IDLE for a header.
            s_axis_tready <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q          <= '0;
            type_q         <= '0;
            expected_seq   <= '0;
            seq_init       <= 1'b0;
            msg_valid      <= 1'b0;
            msg_seq        <= '0;
            msg_type       <= '0;
            msg_price      <= '0;
            msg_qty        <= '0;
            gap_valid      <= 1'b0;
            gap_expected   <= '0;
            gap_received   <= '0;
            err_short      <= 1'b0;
            pkt_accept_cnt <= '0;
            pkt_drop_cnt   <= '0;
        end else begin
            msg_valid <= emit;
            gap_valid <= 1'b0;
            err_short <= short_pkt;

            if (state == W0 && beat) begin
                seq_q  <= s_axis_tdata[63:32];
                type_q <= s_axis_tdata[31:24];
            end

            if (emit) begin
                msg_seq      <= seq_q;
                msg_type     <= type_q;
                msg_price    <= s_axis_tdata[63:32];
                msg_qty      <= s_axis_tdata[31:0];
                seq_init     <= 1'b1;
                expected_seq <= seq_q + 32'd1;   // wraps modulo 2^32
                if (seq_init && (seq_q != expected_seq)) begin
                    gap_valid    <= 1'b1;
                    gap_expected <= expected_seq;
                    gap_received <= seq_q;
                end
                if (pkt_accept_cnt != 16'hFFFF)
                    pkt_accept_cnt <= pkt_accept_cnt + 16'd1;
            end

            if (drop_pkt && (pkt_drop_cnt != 16'hFFFF))
                pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
        end
    end

endmodule

// File: doc/md_feed_decoder.md
Name: md_feed_decoder

Overview:
- Sits directly downstream of rx_parser and consumes its payload AXI-Stream output together with its latched header fields (udp_dport, header_valid).
- Filters packets by configured UDP destination port and decodes the first two payload words into one market-data message (seq, type, price, qty).
- Tracks feed sequence numbers and flags gaps.
- Maintains saturating accept/drop counters for the strategy and monitoring logic.

Parameters:
- DATA_W, 64, stream data width; the decode field map below is fixed for 64.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_W  payload word from rx_parser m_axis_tdata
- s_axis_tvalid  in  1  payload beat valid
- s_axis_tlast  in  1  last payload beat of packet
- s_axis_tready  out  1  beat accept; a beat transfers when tvalid & tready
- header_valid  in  1  rx_parser header fields valid
- udp_dport  in  16  rx_parser UDP destination port
- cfg_dport  in  16  feed port to accept
- cfg_enable  in  1  decoder enable; 0 drops all packets
- msg_valid  out  1  one-cycle pulse, decoded message valid
- msg_seq  out  32  sequence number
- msg_type  out  8  message type
- msg_price  out  32  price
- msg_qty  out  32  quantity
- gap_valid  out  1  one-cycle pulse, sequence gap, coincident with msg_valid
- gap_expected  out  32  expected sequence at gap
- gap_received  out  32  received sequence at gap
- err_short  out  1  one-cycle pulse, packet ended before word 1
- pkt_accept_cnt  out  16  decoded messages, saturating
- pkt_drop_cnt  out  16  dropped packets, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; expected_seq 0; seq_init 0. Reset mid-packet abandons the packet with no pulse.
- Field map:
  - word0: [63:32] seq, [31:24] type, [23:0] ignored.
  - word1: [63:32] price, [31:0] qty.
- s_axis_tready:
  - 0 in IDLE: the upstream holds beats until the header is latched.
  - 1 in W0, W1, DRAIN, DROP.
  - Registered from the state.
- FSM:
  - IDLE: on header_valid, evaluate hit = cfg_enable && (udp_dport == cfg_dport). Hit goes to W0, otherwise DROP. cfg_* and udp_dport are sampled only here; changes mid-packet have no effect.
  - W0: on a beat, latch seq and type. With tlast: err_short pulse, drop_cnt+1, go to IDLE. Without tlast: go to W1.
  - W1: on a beat, latch price and qty and schedule the message. With tlast go to IDLE, otherwise DRAIN.
  - DRAIN: consume beats; on tlast go to IDLE.
  - DROP: consume beats; on tlast, drop_cnt+1 and go to IDLE.
  - header_valid outside IDLE is ignored.
- Latency: msg_valid asserts exactly 1 cycle after the W1 beat handshake. msg_* data holds until the next message.
- pkt_accept_cnt increments in the msg_valid cycle.
- Sequence check, evaluated per emitted message:
  - If seq_init = 0: no gap, seq_init set to 1.
  - Else if seq != expected_seq: gap_valid, gap_expected = expected_seq, gap_received = seq. The message is still emitted.
  - In all cases: expected_seq = seq + 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
- Counters saturate at 0xFFFF and do not wrap.
- A new packet is never merged with a previous one: a header seen in IDLE on the cycle after a tlast is accepted without a bubble.
- Idle beats: tvalid low in W0/W1/DRAIN/DROP holds state.

Test Plan:
1. Decode one message. Setup: cfg_dport=0x1F90, cfg_enable=1, header with udp_dport 0x1F90. Beats 0x00000064_01000000 then 0x00002710_000001F4 with tlast. Required: msg_valid 1 cycle after beat 2, msg_seq=0x64, msg_type=0x01, msg_price=0x2710, msg_qty=0x1F4, accept_cnt=1, gap_valid=0.
2. Sequence gap. Following packets with seq 0x65 then 0x68. Required: 0x65 gives no gap; 0x68 gives gap_valid with gap_expected=0x66 and gap_received=0x68. Then seq 0xFFFFFFFF followed by 0x00000000: exactly one gap (at 0xFFFFFFFF), none at the wrap to 0.
3. Port mismatch. udp_dport=0x04D2, 3 beats. Required: s_axis_tready=1 through tlast, no msg_valid, drop_cnt+1. Repeat with cfg_enable=0 and a matching port: also dropped.
4. Short and long packets. Single beat with tlast: err_short pulse, drop_cnt+1, no msg. 5-beat packet: msg after beat 2, beats 3–5 drained. Next header immediately after tlast: that packet is decoded correctly.
5. Holding in IDLE. tvalid held high with no header: tready stays 0, no beat consumed. header_valid raised: tready rises the next cycle and decoding proceeds.
6. Reset mid-packet. Assert rst asynchronously while in W1. Required: all outputs 0 immediately. After release, packet with seq 0x10: msg_valid, no gap_valid, accept_cnt=1.
